// File: rtl/iitb_risc_pkg.sv
// Shared IITB-RISC types and constants: default PC/counter widths, direction
// counter encodings and the BTB entry layout.
package iitb_risc_pkg;

    localparam int PC_W_DEF  = 16;
    localparam int CTR_W_DEF = 2;

    localparam logic [CTR_W_DEF-1:0] WEAK_TAKEN   = 2'b10;
    localparam logic [CTR_W_DEF-1:0] STRONG_TAKEN = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [PC_W_DEF-1:0]  tag;
        logic [PC_W_DEF-1:0]  target;
        logic [CTR_W_DEF-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Combinational next value of a saturating up/down direction counter.
// Increment clamps at all-ones, decrement clamps at zero.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cnt_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i && (cnt_i != '1)) begin
            cnt_o = cnt_i + CTR_W'(1);
        end else if (dec_i && (cnt_i != '0)) begin
            cnt_o = cnt_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer: zero-latency IF lookup, EX-side
// training/allocation with round-robin eviction, mispredict redirect and perf counters.
module branch_target_buffer
    import iitb_risc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int ENTRIES = 8,
    parameter int CTR_W   = CTR_W_DEF,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [PC_W-1:0]   curr_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [PC_W-1:0]   upd_pc_p1,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WEAK = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [PC_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [PC_W-1:0]   target_d [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];
    logic [CTR_W-1:0]  ctr_d    [ENTRIES];
    logic [CTR_W-1:0]  ctr_nxt  [ENTRIES];
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

    logic              look_hit, upd_hit, have_free;
    logic [IDX_W-1:0]  look_idx, upd_idx, free_idx, victim_idx;

    // Priority encoders scan high-to-low so the lowest matching index wins.
    always_comb begin
        look_hit  = 1'b0;
        look_idx  = '0;
        upd_hit   = 1'b0;
        upd_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == curr_pc)) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
            if (valid_q[i] && (tag_q[i] == upd_pc)) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        victim_idx = have_free ? free_idx : rr_q;
    end

    assign pred_hit    = look_hit;
    assign pred_taken  = look_hit && ctr_q[look_idx][CTR_W-1];
    assign pred_pc     = pred_taken ? target_q[look_idx] : curr_pc + PC_W'(1);
    assign redirect    = upd_valid && (upd_taken != upd_pred_taken);
    assign redirect_pc = upd_taken ? upd_target : upd_pc_p1;

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .cnt_i (ctr_q[g]),
            .inc_i (upd_taken),
            .dec_i (!upd_taken),
            .cnt_o (ctr_nxt[g])
        );
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        rr_d      = rr_q;
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;

        if (upd_valid && (perf_br_q != '1)) perf_br_d = perf_br_q + PERF_W'(1);
        if (redirect && (perf_mp_q != '1))  perf_mp_d = perf_mp_q + PERF_W'(1);

        // Flush wins over a same-cycle table update; perf still counts it.
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
            rr_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx]    = ctr_nxt[upd_idx];
                target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[victim_idx]  = 1'b1;
                tag_d[victim_idx]    = upd_pc;
                target_d[victim_idx] = upd_target;
                ctr_d[victim_idx]    = WEAK;
                if (!have_free) begin
                    rr_d = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            rr_q      <= '0;
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            rr_q      <= rr_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

endmodule
